// File: rtl/wb_scoreboard_if.sv
// Retire-record bus between the reference model, the DUT writeback stage and wb_scoreboard.
// SB_FLAGS_EN adds {Z,V,N} flag fields and the fail_flags status bit.
interface wb_scoreboard_if #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 4,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 16
);
   logic                     exp_valid;
   logic                     exp_ready;
   logic [DATA_W-1:0]        exp_pc;
   logic                     exp_we;
   logic [REG_W-1:0]         exp_rd;
   logic [DATA_W-1:0]        exp_data;
   logic                     dut_valid;
   logic [DATA_W-1:0]        dut_pc;
   logic                     dut_we;
   logic [REG_W-1:0]         dut_rd;
   logic [DATA_W-1:0]        dut_data;
   logic                     dut_hlt;
   logic [$clog2(DEPTH):0]   occupancy;
   logic [CNT_W-1:0]         retired;
   logic                     fail;
   logic [2:0]               fail_code;
   logic [DATA_W-1:0]        fail_pc;
   logic                     done;
`ifdef SB_FLAGS_EN
   logic [2:0]               exp_flags;
   logic [2:0]               dut_flags;
   logic                     fail_flags;
`endif

   modport master (
      output exp_valid, exp_pc, exp_we, exp_rd, exp_data,
      output dut_valid, dut_pc, dut_we, dut_rd, dut_data, dut_hlt,
`ifdef SB_FLAGS_EN
      output exp_flags, dut_flags,
      input  fail_flags,
`endif
      input  exp_ready, occupancy, retired, fail, fail_code, fail_pc, done
   );

   modport slave (
      input  exp_valid, exp_pc, exp_we, exp_rd, exp_data,
      input  dut_valid, dut_pc, dut_we, dut_rd, dut_data, dut_hlt,
`ifdef SB_FLAGS_EN
      input  exp_flags, dut_flags,
      output fail_flags,
`endif
      output exp_ready, occupancy, retired, fail, fail_code, fail_pc, done
   );
endinterface

// File: rtl/wb_scoreboard.sv
// In-order retirement scoreboard: expected records queue up, DUT retires pop and compare (SB_FLAGS_EN adds flags).
// Latency: errors/status registered one cycle after the offending cycle; empty FIFO bypasses same-cycle exp record.
// Backpressure: exp_ready drops when full or failed; a same-cycle pop lets a push into a full FIFO.
module wb_scoreboard #(
   parameter int DATA_W  = 16,
   parameter int REG_W   = 4,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   wb_scoreboard_if.slave sb
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic              we;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
`ifdef SB_FLAGS_EN
      logic [2:0]        flags;
`endif
   } rec_t;

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_PASS, S_FAIL} state_t;

   state_t             r_state, w_state_nxt;
   rec_t               r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wptr, r_rptr;
   logic [OCC_W-1:0]   r_occ;
   logic [TMO_W-1:0]   r_tmo;
   logic [CNT_W-1:0]   r_retired;
   logic               r_fail, r_done;
   logic [2:0]         r_fail_code;
   logic [DATA_W-1:0]  r_fail_pc;
`ifdef SB_FLAGS_EN
   logic               r_fail_flags;
   logic               w_flag_err;
`endif

   rec_t               w_exp_rec, w_dut_rec, w_head;
   logic               w_run, w_active, w_empty, w_full;
   logic               w_pop_req, w_bypass, w_underflow, w_pop, w_push, w_overflow;
   logic               w_idle, w_timeout, w_err, w_match;
   logic [2:0]         w_code;
   logic [DATA_W-1:0]  w_err_pc;

   always_comb begin
      w_exp_rec      = '0;
      w_exp_rec.pc   = sb.exp_pc;
      w_exp_rec.we   = sb.exp_we;
      w_exp_rec.rd   = sb.exp_rd;
      w_exp_rec.data = sb.exp_data;
      w_dut_rec      = '0;
      w_dut_rec.pc   = sb.dut_pc;
      w_dut_rec.we   = sb.dut_we;
      w_dut_rec.rd   = sb.dut_rd;
      w_dut_rec.data = sb.dut_data;
`ifdef SB_FLAGS_EN
      w_exp_rec.flags = sb.exp_flags;
      w_dut_rec.flags = sb.dut_flags;
`endif
   end

   assign w_run       = (r_state == S_RUN);
   assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign w_empty     = (r_occ == '0);
   assign w_full      = (r_occ == OCC_W'(DEPTH));
   assign w_pop_req   = sb.dut_valid & w_active;
   // Bypass only while pushes are still being accepted; in DRAIN an empty pop is an underflow.
   assign w_bypass    = w_pop_req & w_empty & sb.exp_valid & w_run;
   assign w_underflow = w_pop_req & w_empty & ~w_bypass;
   assign w_pop       = w_pop_req & ~w_empty;
   assign w_push      = sb.exp_valid & w_run & ~w_bypass & (~w_full | w_pop);
   assign w_overflow  = sb.exp_valid & w_run & w_full & ~w_pop;
   assign w_idle      = w_active & ~w_empty & ~sb.dut_valid;
   assign w_timeout   = w_idle & (r_tmo == TMO_W'(TIMEOUT - 1));
   assign w_head      = w_empty ? w_exp_rec : r_mem[r_rptr];
   assign w_match     = (w_pop | w_bypass) & ~w_err;

   always_comb begin
      w_code      = 3'd0;
      w_err_pc    = '0;
      w_state_nxt = r_state;
`ifdef SB_FLAGS_EN
      w_flag_err  = 1'b0;
`endif
      if (w_pop | w_bypass) begin
         w_err_pc = sb.dut_pc;
         if (w_head.pc != w_dut_rec.pc)                       w_code = 3'd1;
         else if (w_head.we != w_dut_rec.we)                  w_code = 3'd2;
         else if (w_head.we && (w_head.rd != w_dut_rec.rd))     w_code = 3'd3;
         else if (w_head.we && (w_head.data != w_dut_rec.data)) w_code = 3'd4;
`ifdef SB_FLAGS_EN
         else if (w_head.flags != w_dut_rec.flags) begin
            w_code     = 3'd4;
            w_flag_err = 1'b1;
         end
`endif
      end else if (w_underflow) begin
         w_code   = 3'd5;
         w_err_pc = sb.dut_pc;
      end else if (w_overflow) begin
         w_code   = 3'd6;
         w_err_pc = sb.exp_pc;
      end else if (w_timeout) begin
         w_code   = 3'd7;
         w_err_pc = w_head.pc;
      end
      w_err = (w_code != 3'd0);

      case (r_state)
         S_RUN: begin
            if (w_err)           w_state_nxt = S_FAIL;
            else if (sb.dut_hlt) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_err)                          w_state_nxt = S_FAIL;
            else if (w_empty && !sb.dut_valid)  w_state_nxt = S_PASS;
         end
         default: w_state_nxt = r_state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_RUN;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_occ       <= '0;
         r_tmo       <= '0;
         r_retired   <= '0;
         r_fail      <= 1'b0;
         r_fail_code <= 3'd0;
         r_fail_pc   <= '0;
         r_done      <= 1'b0;
`ifdef SB_FLAGS_EN
         r_fail_flags <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (w_state_nxt == S_PASS);
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
         r_tmo <= w_idle ? r_tmo + TMO_W'(1) : '0;
         if (w_match) r_retired <= r_retired + CNT_W'(1);
         // Only reachable outside FAIL, so the first error sticks.
         if (w_err) begin
            r_fail      <= 1'b1;
            r_fail_code <= w_code;
            r_fail_pc   <= w_err_pc;
`ifdef SB_FLAGS_EN
            r_fail_flags <= w_flag_err;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_exp_rec;
   end

   assign sb.exp_ready = ~w_full & ~r_fail;
   assign sb.occupancy = r_occ;
   assign sb.retired   = r_retired;
   assign sb.fail      = r_fail;
   assign sb.fail_code = r_fail_code;
   assign sb.fail_pc   = r_fail_pc;
   assign sb.done      = r_done;
`ifdef SB_FLAGS_EN
   assign sb.fail_flags = r_fail_flags;
`endif
endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Parametrised retirement scoreboard for the pipelined WISC CPU bench; successor to the single-cycle lock-step check.
- The reference model pushes expected retire records {pc, we, rd, data} into an in-order FIFO.
- The DUT's writeback stage presents actual retire records, possibly several cycles later. Each one pops the head entry and is compared against it.
- Flags the first mismatch, underflow, overflow or timeout, and reports completion after halt drains.

Parameters:
- DATA_W, 16, width of writeback data and PC
- REG_W, 4, register index width
- DEPTH, 8, expected-record FIFO entries (power of 2, >=2)
- TIMEOUT, 64, maximum cycles the FIFO may remain non-empty without a DUT retire
- CNT_W, 16, retire counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- exp_valid  in  1  model pushes an expected record this cycle
- exp_ready  out  1  FIFO not full
- exp_pc  in  DATA_W  expected PC
- exp_we  in  1  expected RegWrite
- exp_rd  in  REG_W  expected destination register
- exp_data  in  DATA_W  expected writeback data
- dut_valid  in  1  DUT retires an instruction this cycle
- dut_pc, dut_we, dut_rd, dut_data  in  DATA_W/1/REG_W/DATA_W  actual retire record
- dut_hlt  in  1  DUT halt asserted
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count
- retired  out  CNT_W  number of successful compares
- fail  out  1  sticky error
- fail_code  out  3  0 none, 1 PC, 2 WE, 3 RD, 4 DATA, 5 underflow, 6 overflow, 7 timeout
- fail_pc  out  DATA_W  dut_pc of the failing retire (exp head PC for timeout; exp_pc for overflow)
- done  out  1  halt seen and FIFO drained with no failure

Behaviour:
- Reset (rst_n low at posedge): FIFO empty, occupancy 0, retired 0, fail 0, fail_code 0, fail_pc 0, done 0, timeout counter 0, state RUN.
- States:
  - RUN: normal operation.
  - DRAIN: entered when dut_hlt=1 is sampled in RUN.
  - PASS: entered from DRAIN when occupancy is 0 and no push or pop is pending; done=1.
  - FAIL: entered from any state on the first error; fail=1. PASS and FAIL are absorbing until reset.
- Push: exp_valid & exp_ready writes the tail.
  - exp_valid while full is an overflow error (code 6); the record is dropped.
  - Pushes are ignored in DRAIN, PASS and FAIL.
- Pop/compare: dut_valid in RUN or DRAIN pops the head. Compare priority is PC, then WE, then RD (only if exp_we), then DATA (only if exp_we). The first mismatch sets fail_code.
  - Match: retired increments by 1, wrapping at 2^CNT_W.
- Empty bypass: dut_valid with FIFO empty and exp_valid in the same cycle compares directly against the incoming exp record; occupancy stays 0.
  - dut_valid with FIFO empty and no exp_valid is underflow (code 5).
- Simultaneous push and pop when non-empty and not full: occupancy unchanged. When full, a simultaneous pop frees the slot, so there is no overflow.
- Timeout: counter increments each cycle that occupancy>0 and dut_valid=0, and clears on any dut_valid or when empty. Reaching TIMEOUT gives code 7.
- Error latency: fail, fail_code and fail_pc are registered and update at the posedge after the offending cycle. Only the first error is recorded.
- Pointers are REG log2(DEPTH) wide and wrap modulo DEPTH. Occupancy is a separate counter.
- Outputs are all registered except exp_ready = (occupancy != DEPTH) & ~fail.

Optional Feature:
- SB_FLAGS_EN: when defined, adds ports exp_flags and dut_flags (3 bits, {Z,V,N}) and stores exp_flags in the FIFO.
  - Flags are compared after DATA; a mismatch uses code 4 with fail_pc and sets an additional output fail_flags=1.
- Undefined: no flag ports, no fail_flags, and the FIFO width excludes flags.

Test Plan:
1. Push 3 records (PC 0x0000/0x0002/0x0004, we=1, rd=1/2/3, data 0x0005/0x000A/0x000F). DUT retires the same records 4 cycles later. Then dut_hlt -> retired=3, done=1, fail=0.
2. Push PC 0x0010 with data 0x1234; DUT retires PC 0x0010 with data 0x1235 -> fail=1, fail_code=4, fail_pc=0x0010. Later retires leave retired unchanged.
3. DEPTH=8: push 9 records with no DUT retire -> 9th cycle exp_ready=0, fail_code=6. Repeat with dut_valid in that same cycle -> no failure, occupancy=8.
4. dut_valid on an empty FIFO with no exp_valid -> fail_code=5. Same-cycle exp_valid with a matching record -> retired=1, occupancy=0.
5. Push 1 record and hold dut_valid=0 for 64 cycles -> fail_code=7 and fail_pc equals the pushed PC. With dut_valid at cycle 63 -> no failure.
6. Apply rst_n=0 mid-operation with occupancy=5 and fail=1 -> next cycle all outputs return to reset values. The scenario 1 sequence then passes.
